// File: rtl/adder_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chk_pkg
//  Description : Shared definitions for the adder result checker: FSM
//                encoding, statistics counter width, default parameters and
//                a saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_chk_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_LATENCY = 3;
    localparam int CNT_W           = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_e;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chk_delay.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chk_delay
//  Description : Fixed-depth shift register carrying a valid flag and a data
//                word, with an "empty" flag that is high when no stage holds
//                a valid entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_chk_delay #(
    parameter int DW    = 9,
    parameter int DEPTH = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          empty
);

    logic [DEPTH-1:0] valid_sr;
    logic [DW-1:0]    data_sr [DEPTH];

    // Shift valid and data one stage per clock; reset discards all entries
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            data_sr[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                data_sr[i]  <= data_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];
    assign empty     = ~|valid_sr;

endmodule
`default_nettype wire

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : adder_result_checker
//  Description : Computes the expected a+b+cin for each valid operand set,
//                delays it to line up with the adder's output, compares, and
//                keeps pass/fail statistics plus a snapshot of the first
//                mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH:0]   dut_sum,
    input  logic             dut_carry,
    input  logic             clear,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             sticky_error,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got,
    output logic [1:0]       state
);

    logic [WIDTH:0] expected;
    logic           dl_valid;
    logic [WIDTH:0] dl_exp;
    logic           dl_empty;
    logic           cmp_pass;
    logic           cmp_fail;
    chk_state_e     state_q;
    chk_state_e     state_d;

    assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    adder_chk_delay #(
        .DW    (WIDTH + 1),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (expected),
        .out_valid (dl_valid),
        .out_data  (dl_exp),
        .empty     (dl_empty)
    );

    // The carry output is checked separately so a bad carry pin is caught
    // even when the wide sum happens to be right.
    assign cmp_pass = (dut_sum == dl_exp) && (dut_carry == dl_exp[WIDTH]);
    assign cmp_fail = dl_valid && !cmp_pass;

    // Register the comparison result as a single-cycle pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
        end else begin
            chk_valid <= dl_valid;
            chk_pass  <= dl_valid && cmp_pass;
        end
    end

    // Statistics and first-mismatch capture; clear takes priority over counting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_count   <= '0;
            fail_count   <= '0;
            sticky_error <= 1'b0;
            first_exp    <= '0;
            first_got    <= '0;
        end else if (clear) begin
            pass_count   <= '0;
            fail_count   <= '0;
            sticky_error <= 1'b0;
            first_exp    <= '0;
            first_got    <= '0;
        end else if (dl_valid) begin
            if (cmp_pass) begin
                pass_count <= sat_inc(pass_count);
            end else begin
                fail_count <= sat_inc(fail_count);
                if (!sticky_error) begin
                    sticky_error <= 1'b1;
                    first_exp    <= dl_exp;
                    first_got    <= dut_sum;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a clear restarts tracking, and an operand arriving on the
    // same edge is still in flight, so it lands in FILL
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = in_valid ? ST_FILL : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) state_d = ST_FILL;
                end
                ST_FILL: begin
                    if (cmp_fail)      state_d = ST_FAIL;
                    else if (dl_valid) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cmp_fail)                  state_d = ST_FAIL;
                    else if (dl_empty && !in_valid) state_d = ST_IDLE;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_result_checker
//  Description : Scoreboard bench for adder_result_checker. Stimulus pushes
//                the expected comparison outcome; a monitor pops on every
//                chk_valid and tracks the statistics the checker should hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_checker;
    import adder_chk_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           cin = 1'b0;
    logic [W:0]     dut_sum = '0;
    logic           dut_carry = 1'b0;
    logic           clear = 1'b0;
    logic           chk_valid;
    logic           chk_pass;
    logic [15:0]    pass_count;
    logic [15:0]    fail_count;
    logic           sticky_error;
    logic [W:0]     first_exp;
    logic [W:0]     first_got;
    logic [1:0]     state;

    always #5 clk = ~clk;

    adder_result_checker #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .dut_sum      (dut_sum),
        .dut_carry    (dut_carry),
        .clear        (clear),
        .chk_valid    (chk_valid),
        .chk_pass     (chk_pass),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .sticky_error (sticky_error),
        .first_exp    (first_exp),
        .first_got    (first_got),
        .state        (state)
    );

    typedef struct packed {
        logic       pass;
        logic [W:0] exp;
        logic [W:0] got;
    } item_t;

    item_t      sbq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    // Adder-output schedule: slot = edge index at which the value must be seen
    logic       sched_v   [64];
    logic [W:0] sched_sum [64];
    logic       sched_c   [64];

    // Monitor-side reference of the statistics
    int         m_pass = 0;
    int         m_fail = 0;
    logic       m_sticky = 1'b0;
    logic [W:0] m_fexp = '0;
    logic [W:0] m_fgot = '0;
    int         run = 0;
    int         maxrun = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic flush_sched();
        for (int i = 0; i < 64; i++) begin
            sched_v[i]   = 1'b0;
            sched_sum[i] = '0;
            sched_c[i]   = 1'b0;
        end
    endtask

    // Play the adder: present the scheduled result, otherwise noise
    always @(negedge clk) begin
        int idx;
        idx = (cyc + 1) % 64;
        if (sched_v[idx] === 1'b1) begin
            dut_sum      = sched_sum[idx];
            dut_carry    = sched_c[idx];
            sched_v[idx] = 1'b0;
        end else begin
            dut_sum   = (W+1)'($urandom);
            dut_carry = 1'($urandom);
        end
    end

    // Drive one transaction now (at a negedge) and advance to the next negedge
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                        input logic [W:0] sum, input logic carry, input logic clr);
        logic [W:0] e;
        int         slot;
        item_t      it;
        e         = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
        in_valid  = 1'b1;
        a         = aa;
        b         = bb;
        cin       = cc;
        clear     = clr;
        slot      = (cyc + 1 + LAT) % 64;
        sched_v[slot]   = 1'b1;
        sched_sum[slot] = sum;
        sched_c[slot]   = carry;
        it.pass   = (sum == e) && (carry == e[W]);
        it.exp    = e;
        it.got    = sum;
        sbq.push_back(it);
        @(negedge clk);
    endtask

    // mode 0: correct adder, 1: one sum bit wrong, 2: carry pin wrong
    task automatic send_rand(input int mode, input logic clr);
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   e;
        logic [W:0]   s;
        logic         c;
        logic [W:0]   flip;
        aa = W'($urandom);
        bb = W'($urandom);
        cc = 1'($urandom);
        e  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
        s  = e;
        c  = e[W];
        if (mode == 1) begin
            flip = (W+1)'(1) << $urandom_range(0, W);
            s    = e ^ flip;
        end else if (mode == 2) begin
            c = ~e[W];
        end
        send(aa, bb, cc, s, c, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            clear    = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        sbq.delete();
        flush_sched();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_chk(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (chk_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        check("chk_valid_seen", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) idle(1);
        check("drain_queue_empty", sbq.size(), 0);
        idle(2);
    endtask

    // Scoreboard monitor: sample just after each rising edge
    always begin
        item_t it;
        @(posedge clk);
        #1;
        if (!resetn) begin
            m_pass = 0; m_fail = 0; m_sticky = 1'b0; m_fexp = '0; m_fgot = '0;
            run = 0;
        end else begin
            if (chk_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_chk_valid: got=1 expected=0 (t=%0t)", $time);
                end else begin
                    it = sbq.pop_front();
                    check("chk_pass", 32'(chk_pass), 32'(it.pass));
                    if (!clear) begin
                        if (it.pass) begin
                            if (m_pass < 65535) m_pass++;
                        end else begin
                            if (m_fail < 65535) m_fail++;
                            if (!m_sticky) begin
                                m_sticky = 1'b1;
                                m_fexp   = it.exp;
                                m_fgot   = it.got;
                            end
                        end
                    end
                end
            end else begin
                run = 0;
            end
            if (clear) begin
                m_pass = 0; m_fail = 0; m_sticky = 1'b0; m_fexp = '0; m_fgot = '0;
            end
            if (chk_valid || clear) begin
                check("pass_count", 32'(pass_count), m_pass);
                check("fail_count", 32'(fail_count), m_fail);
                check("sticky_error", 32'(sticky_error), 32'(m_sticky));
                check("first_exp", 32'(first_exp), 32'(m_fexp));
                check("first_got", 32'(first_got), 32'(m_fgot));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int at;
        int n;
        int r;
        flush_sched();
        @(negedge clk);
        #1;
        // Reset state
        check("rst_chk_valid", 32'(chk_valid), 0);
        check("rst_chk_pass", 32'(chk_pass), 0);
        check("rst_pass_count", 32'(pass_count), 0);
        check("rst_fail_count", 32'(fail_count), 0);
        check("rst_sticky", 32'(sticky_error), 0);
        check("rst_first_exp", 32'(first_exp), 0);
        check("rst_first_got", 32'(first_got), 0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;

        // Single passing transaction on the very first edge after release
        n = cyc + 1;
        send(8'd200, 8'd100, 1'b1, 9'd301, 1'b1, 1'b0);
        idle(1);
        wait_chk(ok, at);
        check("latency", at - n, LAT);
        check("single_pass_count", 32'(pass_count), 1);
        check("single_state_run", 32'(state), 32'(ST_RUN));
        idle(2);
        check("run_to_idle", 32'(state), 32'(ST_IDLE));

        // Wrong sum: 255+1 should be 0x100
        send(8'hFF, 8'h01, 1'b0, 9'h000, 1'b0, 1'b0);
        idle(1);
        wait_chk(ok, at);
        check("mis_fail_count", 32'(fail_count), 1);
        check("mis_sticky", 32'(sticky_error), 1);
        check("mis_first_exp", 32'(first_exp), 32'h100);
        check("mis_first_got", 32'(first_got), 32'h000);
        check("mis_state_fail", 32'(state), 32'(ST_FAIL));

        // Correct sum, wrong carry pin; snapshot must not move
        send(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0);
        idle(1);
        wait_chk(ok, at);
        check("carry_fail_count", 32'(fail_count), 2);
        check("carry_first_got_kept", 32'(first_got), 32'h000);
        check("carry_state_fail", 32'(state), 32'(ST_FAIL));

        // Plain clear
        do_clear();
        idle(1);
        check("clear_state_idle", 32'(state), 32'(ST_IDLE));
        check("clear_fail_count", 32'(fail_count), 0);

        // 20 back-to-back correct transactions
        maxrun = 0;
        for (int i = 0; i < 20; i++) send_rand(0, 1'b0);
        idle(1);
        drain();
        check("burst_consecutive", maxrun, 20);
        check("burst_pass_count", 32'(pass_count), 20);
        check("burst_fail_count", 32'(fail_count), 0);

        // Clear coincident with a failing comparison
        do_clear();
        send(8'hFF, 8'h01, 1'b0, 9'h000, 1'b0, 1'b0);
        idle(2);
        do_clear();
        check("clrcmp_chk_valid", 32'(chk_valid), 1);
        check("clrcmp_chk_pass", 32'(chk_pass), 0);
        check("clrcmp_fail_count", 32'(fail_count), 0);
        check("clrcmp_sticky", 32'(sticky_error), 0);
        check("clrcmp_state", 32'(state), 32'(ST_IDLE));
        idle(1);

        // Operand together with clear goes into the pipe, state FILL
        send_rand(0, 1'b1);
        check("clr_valid_state_fill", 32'(state), 32'(ST_FILL));
        idle(1);
        drain();

        // Random mix of good, bad, idle and clear cycles
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       send_rand((r < 4) ? 0 : $urandom_range(1, 2), 1'($urandom_range(0, 15) == 0));
            else if (r == 9) do_clear();
            else             idle(1);
        end
        idle(1);
        drain();

        // Reset with two transactions in flight
        send_rand(0, 1'b0);
        send_rand(1, 1'b0);
        do_reset();
        idle(8);
        check("rst_mid_pass_count", 32'(pass_count), 0);
        check("rst_mid_fail_count", 32'(fail_count), 0);
        check("rst_mid_state", 32'(state), 32'(ST_IDLE));
        check("rst_mid_chk_valid", 32'(chk_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
